// File: rtl/cic_offset_ctrl_pkg.sv
// rtl/cic_offset_ctrl_pkg.sv - shared constants, FSM encodings and FIFO entry layout for the CIC offset ROM controller
package cic_offset_ctrl_pkg;

    localparam int DEF_DW         = 16;
    localparam int DEF_CHAN_W     = 8;
    localparam int ROM_ADDR_W     = DEF_CHAN_W + 1;
    localparam int DEF_ROM_LAT    = 3;
    localparam int DEF_FIFO_DEPTH = 8;

    localparam logic [0:0] FRAME_START = 1'b0;
    localparam logic [0:0] IN_FRAME    = 1'b1;

    // Offset sits in the LSB so the ROM bit concatenates directly onto the sideband.
    typedef struct packed {
        logic                  last;
        logic [DEF_CHAN_W-1:0] chan;
        logic [DEF_DW-1:0]     data;
        logic                  offset;
    } fifo_entry_t;

endpackage

// File: rtl/cic_offset_sync_fifo.sv
// rtl/cic_offset_sync_fifo.sv - first-word-fall-through sync FIFO with occupancy count
module cic_offset_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_rd;

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign do_rd    = rd_en && rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cic_offset_rom_ctrl.sv
// rtl/cic_offset_rom_ctrl.sv - sequences per-channel offset ROM lookups and re-aligns the offset bit with each sample
module cic_offset_rom_ctrl
    import cic_offset_ctrl_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int CHAN_W     = DEF_CHAN_W,
    parameter int ROM_LAT    = DEF_ROM_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHAN_W-1:0] s_chan,
    input  logic [DW-1:0]     s_data,
    input  logic              s_last,
    input  logic              bank_req,
    input  logic              bank_upd,
    output logic [CHAN_W:0]   rom_addr,
    input  logic              rom_doa,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic [CHAN_W-1:0] m_chan,
    output logic              m_offset,
    output logic              m_last,
    output logic              active_bank,
    output logic              bank_pending
);

    localparam int SBW = DW + CHAN_W + 1;
    localparam int EW  = SBW + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic             rdy_en;
    logic             accept;
    logic [0:0]       state;
    logic             pending_val;
    logic             apply;
    logic [ROM_LAT:0] pv;
    logic [SBW-1:0]   psb [ROM_LAT+1];
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    credits;
    logic [EW-1:0]    fifo_rd;

    // Credits are derived from what is actually held, so they cannot drift from the pipe and FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= ROM_LAT; i++) begin
            in_flight = in_flight + {{(CW-1){1'b0}}, pv[i]};
        end
    end

    assign credits = CW'(FIFO_DEPTH) - in_flight - fifo_count;
    assign s_ready = rdy_en && (credits != '0);
    assign accept  = s_valid && s_ready;
    assign apply   = bank_pending &&
                     (((state == FRAME_START) && !accept) || (accept && s_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            rom_addr <= '0;
            pv       <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                psb[i] <= '0;
            end
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                rom_addr <= {active_bank, s_chan};
            end
            // Stage 0 lines up with rom_addr; the last stage lines up with rom_doa.
            pv     <= {pv[ROM_LAT-1:0], accept};
            psb[0] <= {s_last, s_chan, s_data};
            for (int i = 1; i <= ROM_LAT; i++) begin
                psb[i] <= psb[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FRAME_START;
            active_bank  <= 1'b0;
            pending_val  <= 1'b0;
            bank_pending <= 1'b0;
        end else begin
            if (accept) begin
                state <= s_last ? FRAME_START : IN_FRAME;
            end
            if (apply) begin
                active_bank  <= pending_val;
                bank_pending <= 1'b0;
            end
            // A fresh request wins over the clear, so it stays pending for the next boundary.
            if (bank_upd) begin
                pending_val  <= bank_req;
                bank_pending <= 1'b1;
            end
        end
    end

    cic_offset_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (pv[ROM_LAT]),
        .wr_data  ({psb[ROM_LAT], rom_doa}),
        .rd_en    (m_ready),
        .rd_data  (fifo_rd),
        .rd_valid (m_valid),
        .count    (fifo_count)
    );

    assign {m_last, m_chan, m_data, m_offset} = fifo_rd;

endmodule

// File: tb/tb_cic_offset_rom_ctrl.sv
// tb/tb_cic_offset_rom_ctrl.sv - scoreboard bench for cic_offset_rom_ctrl with a 3-cycle ROM model
module tb_cic_offset_rom_ctrl;

    typedef struct packed {
        logic        last;
        logic [7:0]  chan;
        logic [15:0] data;
        logic        off;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_chan;
    logic [15:0] s_data;
    logic        s_last;
    logic        bank_req;
    logic        bank_upd;
    logic [8:0]  rom_addr;
    logic        rom_doa;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [7:0]  m_chan;
    logic        m_offset;
    logic        m_last;
    logic        active_bank;
    logic        bank_pending;

    logic rom [0:511];
    logic rom_d1, rom_d2;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   pop_cnt = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    int   max_out = 0;
    bit   rnd_run = 0;

    cic_offset_rom_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_chan       (s_chan),
        .s_data       (s_data),
        .s_last       (s_last),
        .bank_req     (bank_req),
        .bank_upd     (bank_upd),
        .rom_addr     (rom_addr),
        .rom_doa      (rom_doa),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_chan       (m_chan),
        .m_offset     (m_offset),
        .m_last       (m_last),
        .active_bank  (active_bank),
        .bank_pending (bank_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rom_d1  <= rom[rom_addr];
        rom_d2  <= rom_d1;
        rom_doa <= rom_d2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got chan 0x%0h expected no output", m_chan);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(m_data), 32'(e.data));
                chk("out_chan", 32'(m_chan), 32'(e.chan));
                chk("out_last", 32'(m_last), 32'(e.last));
                chk("out_offset", 32'(m_offset), 32'(e.off));
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] ch, input logic [15:0] d, input logic l, input logic b);
        bit done;
        done    = 0;
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        s_last  = l;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (s_ready) begin
                sb.push_back(exp_t'{l, ch, d, rom[{b, ch}]});
                if (sb.size() > max_out) max_out = sb.size();
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: chan 0x%0h not accepted within 100 cycles", ch);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d outputs still missing", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill8(input logic b);
        int n;
        n       = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_chan = 8'(n);
            s_data = 16'h2000 + 16'(n);
            s_last = (n == 7);
            @(negedge clk);
            if (s_ready) begin
                sb.push_back(exp_t'{s_last, s_chan, s_data, rom[{b, s_chan}]});
                n++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("fill_accepts", 32'(n), 32'd8);
        @(negedge clk);
        chk("fill_s_ready_low", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s_ready_after_pop", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic pulse_bank(input logic b);
        bank_req = b;
        bank_upd = 1'b1;
        @(posedge clk);
        #1;
        bank_upd = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rnd_run) m_ready <= $urandom_range(0, 1) != 0;
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 1'b0;
        rom[9'h005] = 1'b1;
        rom[9'h100] = 1'b1;
        for (int i = 3; i < 8; i++) rom[9'h100 + i] = 1'b1;
        rst_n = 1'b0; s_valid = 1'b0; s_chan = '0; s_data = '0; s_last = 1'b0;
        bank_req = 1'b0; bank_upd = 1'b0; m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_active_bank", 32'(active_bank), 32'd0);
        chk("rst_bank_pending", 32'(bank_pending), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: back-to-back frame, latency and no bubbles
        begin
            int t0;
            pop_cnt = 0;
            send(8'd0, 16'h1000, 1'b0, 1'b0);
            t0 = acc_cyc;
            for (int c = 1; c < 8; c++) send(8'(c), 16'h1000 + 16'(c), c == 7, 1'b0);
            drain();
            chk("t1_latency", 32'(first_pop_cyc - t0), 32'd5);
            chk("t1_no_bubbles", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
            chk("t1_count", 32'(pop_cnt), 32'd8);
        end

        // 2: backpressure fills exactly FIFO_DEPTH credits
        fill8(1'b0);

        // 3: mid-frame bank request applied at frame end
        for (int c = 0; c < 3; c++) send(8'(c), 16'h3000 + 16'(c), 1'b0, 1'b0);
        pulse_bank(1'b1);
        @(negedge clk);
        chk("t3_pending", 32'(bank_pending), 32'd1);
        chk("t3_active_hold", 32'(active_bank), 32'd0);
        @(posedge clk);
        #1;
        for (int c = 3; c < 8; c++) send(8'(c), 16'h3000 + 16'(c), c == 7, 1'b0);
        @(negedge clk);
        chk("t3_active_applied", 32'(active_bank), 32'd1);
        chk("t3_pending_clear", 32'(bank_pending), 32'd0);
        @(posedge clk);
        #1;
        send(8'd0, 16'h3100, 1'b1, 1'b1);
        @(negedge clk);
        chk("t3_rom_addr_bank1", 32'(rom_addr), 32'h100);
        @(posedge clk);
        #1;
        drain();

        // 4: idle swap, then two requests mid-frame
        pulse_bank(1'b0);
        @(negedge clk);
        chk("t4_idle_pending", 32'(bank_pending), 32'd1);
        chk("t4_idle_old_bank", 32'(active_bank), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_idle_applied", 32'(active_bank), 32'd0);
        @(posedge clk);
        #1;
        pulse_bank(1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_idle_back_to_1", 32'(active_bank), 32'd1);
        @(posedge clk);
        #1;
        send(8'd0, 16'h4000, 1'b0, 1'b1);
        pulse_bank(1'b1);
        pulse_bank(1'b0);
        for (int c = 1; c < 8; c++) send(8'(c), 16'h4000 + 16'(c), c == 7, 1'b1);
        @(negedge clk);
        chk("t4_last_pulse_wins", 32'(active_bank), 32'd0);
        chk("t4_pending_clear", 32'(bank_pending), 32'd0);
        @(posedge clk);
        #1;
        send(8'd0, 16'h4100, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_rom_addr_bank0", 32'(rom_addr), 32'h000);
        @(posedge clk);
        #1;
        drain();

        // 5: random handshakes against random ROM contents
        for (int i = 0; i < 512; i++) rom[i] = $urandom_range(0, 1) != 0;
        max_out = 0;
        rnd_run = 1;
        for (int n = 0; n < 400; n++) begin
            int idle;
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom_range(0, 255)), 16'($urandom), $urandom_range(0, 1) != 0, 1'b0);
        end
        rnd_run = 0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        chk("t5_max_outstanding_le_depth", 32'(max_out <= 8), 32'd1);

        // 6: reset with 3 beats in flight and 4 queued
        pulse_bank(1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b0;
        for (int c = 0; c < 7; c++) send(8'(c), 16'h6000 + 16'(c), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid_at_reset", 32'(m_valid), 32'd0);
        chk("t6_s_ready_at_reset", 32'(s_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        chk("t6_s_ready_during_reset", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("t6_active_bank", 32'(active_bank), 32'd0);
        chk("t6_m_valid_after", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_s_ready_after", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        fill8(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
